// File: rtl/muldiv_seq.sv
// muldiv_seq: iterative MULT/MULTU/DIV/DIVU engine for the execute stage.
// Runs one shift-add (multiply) or restoring-subtract (divide) step per cycle
// through the shared ALU, then applies sign fixup and writes HI/LO.
module muldiv_seq #(
  parameter int ITER = 32
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [1:0]  op,
  input  logic [31:0] rs_val,
  input  logic [31:0] rt_val,
  output logic        busy,
  output logic        done,
  output logic [31:0] hi,
  output logic [31:0] lo,
  output logic        div_by_zero,
  output logic [3:0]  alu_opselect,
  output logic [31:0] alu_x,
  output logic [31:0] alu_y,
  input  logic [31:0] alu_res,
  input  logic        alu_c_out
);

  localparam int CW = $clog2(ITER);
  localparam logic [CW-1:0] LAST = CW'(ITER - 1);

  localparam logic [3:0] ALU_ADD = 4'b0000;
  localparam logic [3:0] ALU_SUB = 4'b0001;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ITER  = 2'd1,
    ST_FIXUP = 2'd2
  } state_t;

  // op[1] selects divide, op[0] selects signed
  state_t        state_q, state_d;
  logic [1:0]    op_q, op_d;
  logic          sign_a_q, sign_a_d;
  logic          sign_b_q, sign_b_d;
  logic [31:0]   a_q, a_d;      // |multiplicand| or |divisor|
  logic [31:0]   q_q, q_d;      // |multiplier| / |dividend|, becomes product low / quotient
  logic [31:0]   acc_q, acc_d;  // product high / partial remainder
  logic [CW-1:0] cnt_q, cnt_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;
  logic [31:0]   hi_q, hi_d;
  logic [31:0]   lo_q, lo_d;
  logic          dbz_q, dbz_d;

  // Operand magnitudes for signed ops; negation is local, never via the ALU
  logic [31:0] rs_mag, rt_mag;
  logic        rs_neg, rt_neg;
  assign rs_neg = op[0] & rs_val[31];
  assign rt_neg = op[0] & rt_val[31];
  assign rs_mag = rs_neg ? (~rs_val + 32'd1) : rs_val;
  assign rt_mag = rt_neg ? (~rt_val + 32'd1) : rt_val;

  // Multiply step: conditionally take the ALU sum, then shift {carry,acc,q} right
  logic [32:0] mul_sum;
  assign mul_sum = q_q[0] ? {alu_c_out, alu_res} : {1'b0, acc_q};

  // Divide step: shift in the next dividend bit; R[31] set means the shifted
  // value already exceeds any 32-bit divisor, so the subtract is always taken
  logic [31:0] rem_sh;
  logic        rem_take;
  assign rem_sh   = {acc_q[30:0], q_q[31]};
  assign rem_take = acc_q[31] | alu_c_out;

  // Fixup values
  logic [63:0] prod, prod_neg;
  logic [31:0] quo_neg, rem_neg, dvd_raw;
  assign prod     = {acc_q, q_q};
  assign prod_neg = ~prod + 64'd1;
  assign quo_neg  = ~q_q + 32'd1;
  assign rem_neg  = ~acc_q + 32'd1;
  // On divide-by-zero q still holds the dividend magnitude; restore its sign
  assign dvd_raw  = sign_a_q ? quo_neg : q_q;

  // ALU drive: active only while iterating, zero otherwise
  always_comb begin
    alu_opselect = ALU_ADD;
    alu_x        = 32'd0;
    alu_y        = 32'd0;
    if (state_q == ST_ITER) begin
      alu_y = a_q;
      if (op_q[1]) begin
        alu_opselect = ALU_SUB;
        alu_x        = rem_sh;
      end else begin
        alu_opselect = ALU_ADD;
        alu_x        = acc_q;
      end
    end
  end

  // Next-state and datapath update
  always_comb begin
    state_d  = state_q;
    op_d     = op_q;
    sign_a_d = sign_a_q;
    sign_b_d = sign_b_q;
    a_d      = a_q;
    q_d      = q_q;
    acc_d    = acc_q;
    cnt_d    = cnt_q;
    busy_d   = busy_q;
    done_d   = 1'b0;
    hi_d     = hi_q;
    lo_d     = lo_q;
    dbz_d    = dbz_q;

    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          op_d     = op;
          sign_a_d = rs_neg;
          sign_b_d = rt_neg;
          acc_d    = 32'd0;
          cnt_d    = '0;
          busy_d   = 1'b1;
          dbz_d    = 1'b0;
          if (op[1]) begin
            q_d = rs_mag;
            a_d = rt_mag;
            if (rt_val == 32'd0) begin
              dbz_d   = 1'b1;
              state_d = ST_FIXUP;
            end else begin
              state_d = ST_ITER;
            end
          end else begin
            q_d     = rt_mag;
            a_d     = rs_mag;
            state_d = ST_ITER;
          end
        end
      end

      ST_ITER: begin
        if (op_q[1]) begin
          if (rem_take) begin
            acc_d = alu_res;
            q_d   = {q_q[30:0], 1'b1};
          end else begin
            acc_d = rem_sh;
            q_d   = {q_q[30:0], 1'b0};
          end
        end else begin
          acc_d = mul_sum[32:1];
          q_d   = {mul_sum[0], q_q[31:1]};
        end
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == LAST) state_d = ST_FIXUP;
      end

      ST_FIXUP: begin
        if (dbz_q) begin
          hi_d = dvd_raw;
          lo_d = 32'hFFFF_FFFF;
        end else if (op_q[1]) begin
          lo_d = (sign_a_q ^ sign_b_q) ? quo_neg : q_q;
          hi_d = sign_a_q ? rem_neg : acc_q;
        end else if (sign_a_q ^ sign_b_q) begin
          {hi_d, lo_d} = prod_neg;
        end else begin
          {hi_d, lo_d} = prod;
        end
        done_d  = 1'b1;
        busy_d  = 1'b0;
        state_d = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  // State and result registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      op_q     <= 2'd0;
      sign_a_q <= 1'b0;
      sign_b_q <= 1'b0;
      a_q      <= 32'd0;
      q_q      <= 32'd0;
      acc_q    <= 32'd0;
      cnt_q    <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      hi_q     <= 32'd0;
      lo_q     <= 32'd0;
      dbz_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      sign_a_q <= sign_a_d;
      sign_b_q <= sign_b_d;
      a_q      <= a_d;
      q_q      <= q_d;
      acc_q    <= acc_d;
      cnt_q    <= cnt_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      dbz_q    <= dbz_d;
    end
  end

  assign busy        = busy_q;
  assign done        = done_q;
  assign hi          = hi_q;
  assign lo          = lo_q;
  assign div_by_zero = dbz_q;

endmodule

// File: tb/tb_muldiv_seq.sv
// tb_muldiv_seq: directed bench for muldiv_seq with a behavioural ALU and a
// result scoreboard checked on every done pulse.
module tb_muldiv_seq;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [1:0]  op = 2'd0;
  logic [31:0] rs_val = 32'd0;
  logic [31:0] rt_val = 32'd0;
  logic        busy, done, div_by_zero;
  logic [31:0] hi, lo;
  logic [3:0]  alu_opselect;
  logic [31:0] alu_x, alu_y, alu_res;
  logic        alu_c_out;

  muldiv_seq #(.ITER(32)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .op(op),
    .rs_val(rs_val), .rt_val(rt_val),
    .busy(busy), .done(done), .hi(hi), .lo(lo), .div_by_zero(div_by_zero),
    .alu_opselect(alu_opselect), .alu_x(alu_x), .alu_y(alu_y),
    .alu_res(alu_res), .alu_c_out(alu_c_out)
  );

  always #5 clk = ~clk;

  // ALU: add with carry-out, subtract with carry-out = no borrow
  always_comb begin
    {alu_c_out, alu_res} = 33'd0;
    case (alu_opselect)
      4'b0000: {alu_c_out, alu_res} = {1'b0, alu_x} + {1'b0, alu_y};
      4'b0001: {alu_c_out, alu_res} = {1'b0, alu_x} + {1'b0, ~alu_y} + 33'd1;
      default: {alu_c_out, alu_res} = 33'd0;
    endcase
  end

  typedef struct {
    logic [31:0] hi;
    logic [31:0] lo;
    logic        dbz;
    string       tag;
  } exp_t;

  exp_t sb[$];
  exp_t e;
  int   n_chk  = 0;
  int   n_pass = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  // Scoreboard: every done pulse pops and checks one expected result
  always @(negedge clk) begin
    if (done === 1'b1) begin
      if (sb.size() == 0) begin
        chk("unexpected_done", {63'd0, done}, 64'd0);
      end else begin
        e = sb.pop_front();
        chk({e.tag, "_hi"}, {32'd0, hi}, {32'd0, e.hi});
        chk({e.tag, "_lo"}, {32'd0, lo}, {32'd0, e.lo});
        chk({e.tag, "_dbz"}, {63'd0, div_by_zero}, {63'd0, e.dbz});
      end
    end
  end

  // Issue one op starting now, measure latency to done; optionally pulse a
  // conflicting start at iteration inj_at
  task automatic do_op(input string tag, input logic [1:0] o,
                       input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] eh, input logic [31:0] el,
                       input logic ed, input int elat, input int inj_at);
    int lat;
    bit busy_ok;
    sb.push_back('{eh, el, ed, tag});
    start = 1'b1; op = o; rs_val = a; rt_val = b;
    @(posedge clk); #1;
    start = 1'b0; op = ~o; rs_val = 32'h0BAD_F00D; rt_val = 32'h1357_9BDF;
    chk({tag, "_accept"}, {62'd0, busy, div_by_zero}, {62'd0, 1'b1, ed});
    chk({tag, "_aluop"}, {60'd0, alu_opselect},
        {60'd0, (o[1] && b != 32'd0) ? 4'b0001 : 4'b0000});
    lat = 0;
    busy_ok = 1'b1;
    while (lat < 100) begin
      @(posedge clk); #1;
      lat++;
      if (done) break;
      if (!busy) busy_ok = 1'b0;
      if (lat == inj_at) begin
        start = 1'b1; op = 2'b00; rs_val = 32'h1111_1111; rt_val = 32'h2222_2222;
      end else begin
        start = 1'b0;
      end
    end
    start = 1'b0;
    chk({tag, "_latency"}, 64'(lat), 64'(elat));
    chk({tag, "_busy_hold"}, {63'd0, busy_ok}, 64'd1);
    chk({tag, "_busy_at_done"}, {62'd0, busy, done}, {62'd0, 1'b0, 1'b1});
  endtask

  // Idle for n cycles, then confirm results and flag held and ALU parked
  task automatic idle_hold(input string tag, input int n, input logic [31:0] eh,
                           input logic [31:0] el, input logic ed);
    repeat (n) @(posedge clk);
    #1;
    chk({tag, "_hold"}, {hi, lo}, {eh, el});
    chk({tag, "_hold_ctl"}, {61'd0, busy, done, div_by_zero}, {61'd0, 1'b0, 1'b0, ed});
    chk({tag, "_alu_idle"}, {28'd0, alu_opselect, alu_x}, 64'd0);
  endtask

  initial begin : main
    bit done_seen;
    rst_n = 1'b0;
    #12;
    chk("reset_ctl", {57'd0, busy, done, div_by_zero, alu_opselect}, 64'd0);
    chk("reset_data", {hi, lo}, 64'd0);
    chk("reset_alu", {alu_x, alu_y}, 64'd0);
    @(negedge clk) rst_n = 1'b1;
    @(negedge clk);

    do_op("multu_max", 2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, 1'b0, 33, -1);
    idle_hold("multu_max", 3, 32'hFFFF_FFFE, 32'h0000_0001, 1'b0);

    // Consecutive calls issue start during the previous op's done cycle
    do_op("mult_neg", 2'b01, 32'hFFFF_FFFD, 32'd5, 32'hFFFF_FFFF, 32'hFFFF_FFF1, 1'b0, 33, -1);
    do_op("mult_min", 2'b01, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0, 1'b0, 33, -1);
    do_op("div_neg", 2'b11, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0, 33, -1);
    do_op("divu", 2'b10, 32'd100, 32'd7, 32'd2, 32'd14, 1'b0, 33, -1);
    do_op("div_ovf", 2'b11, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0, 32'h8000_0000, 1'b0, 33, -1);

    do_op("divu_zero", 2'b10, 32'h64, 32'd0, 32'h64, 32'hFFFF_FFFF, 1'b1, 1, -1);
    idle_hold("divu_zero", 2, 32'h64, 32'hFFFF_FFFF, 1'b1);
    do_op("divu_after_dz", 2'b10, 32'd100, 32'd7, 32'd2, 32'd14, 1'b0, 33, -1);

    do_op("multu_inj", 2'b00, 32'd6, 32'd7, 32'd0, 32'd42, 1'b0, 33, 5);
    idle_hold("multu_inj", 3, 32'd0, 32'd42, 1'b0);

    // Reset during iteration 10 of a multiply
    start = 1'b1; op = 2'b00; rs_val = 32'h1234_5678; rt_val = 32'd3;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (10) @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    chk("midrst_ctl", {61'd0, busy, done, div_by_zero}, 64'd0);
    chk("midrst_data", {hi, lo}, 64'd0);
    chk("midrst_alu", {28'd0, alu_opselect, alu_x}, 64'd0);
    @(negedge clk) rst_n = 1'b1;
    done_seen = 1'b0;
    repeat (40) begin
      @(posedge clk); #1;
      if (done) done_seen = 1'b1;
    end
    chk("midrst_no_done", {63'd0, done_seen}, 64'd0);
    chk("midrst_idle", {62'd0, busy, div_by_zero}, 64'd0);

    do_op("multu_post_rst", 2'b00, 32'd6, 32'd7, 32'd0, 32'd42, 1'b0, 33, -1);
    idle_hold("multu_post_rst", 2, 32'd0, 32'd42, 1'b0);

    chk("sb_drained", 64'(sb.size()), 64'd0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/muldiv_seq.md
# muldiv_seq

Multi-cycle multiply/divide sequencer for the execute stage. It implements MIPS MULT, MULTU, DIV and DIVU by driving the shared 32-bit ALU through its add (0000) and subtract (0001) operations, one iteration per cycle. Results go to the HI/LO registers it owns. The pipeline stalls on `busy` and reads `hi`/`lo` for MFHI/MFLO.

## Interface
Parameters:
- `ITER`, 32: number of iterations, equal to the operand width; fixed, not user-tunable.

Ports:
- `clk` in 1: single clock, rising edge.
- `rst_n` in 1: reset, asynchronous, active-low.
- `start` in 1: request; sampled only when `busy`=0.
- `op` in 2: 00 MULTU, 01 MULT, 10 DIVU, 11 DIV.
- `rs_val` in 32: multiplicand / dividend.
- `rt_val` in 32: multiplier / divisor.
- `busy` out 1: operation in progress.
- `done` out 1: one-cycle pulse; `hi`/`lo` are valid and newly written.
- `hi` out 32: product[63:32] or remainder.
- `lo` out 32: product[31:0] or quotient.
- `div_by_zero` out 1: flag for the last completed divide; cleared by the next accepted `start`.
- `alu_opselect` out 4: to the ALU.
- `alu_x` out 32: to the ALU.
- `alu_y` out 32: to the ALU.
- `alu_res` in 32: from the ALU (combinational, same cycle).
- `alu_c_out` in 1: from the ALU.

## Operation
FSM states: IDLE, ITER, FIXUP.

- **Reset values:** all outputs are 0 and the state is IDLE. This includes `hi`, `lo`, `busy`, `done`, `div_by_zero` and the ALU drive outputs.

- **IDLE + start:**
  - Latch `op`.
  - For signed ops, latch operand magnitudes (two's-complement negation in internal logic, not the ALU) plus `sign_a` and `sign_b`. Unsigned ops latch raw values.
  - Clear `div_by_zero`, set `busy`, reset the counter to 0.
  - Divide with `rt_val`=0: go straight to FIXUP with `div_by_zero`=1.
  - Otherwise go to ITER.

- **ITER, multiply** (A = {carry, acc[31:0], q[31:0]}, acc=0, q=|multiplier|):
  - Drive `alu_opselect`=0000, `alu_x`=acc, `alu_y`=|multiplicand|.
  - If q[0]=1: {carry, acc} = {`alu_c_out`, `alu_res`}; otherwise {carry, acc} = {0, acc}.
  - Then shift {carry, acc, q} right by 1.

- **ITER, divide** (R=0, q=|dividend|, d=|divisor|):
  - Drive `alu_opselect`=0001, `alu_x`={R[30:0], q[31]}, `alu_y`=d.
  - If R[31] | `alu_c_out` (no borrow): R=`alu_res` and the new q LSB is 1.
  - Otherwise R={R[30:0], q[31]} and the new q LSB is 0.
  - q shifts left in both cases.

- **Leaving ITER:** the counter increments each ITER cycle; ITER ends after iteration 31 and the FSM goes to FIXUP.

- **FIXUP** writes `hi`/`lo`, pulses `done`, clears `busy` and returns to IDLE:
  - **MULTU:** {`hi`,`lo`} = {acc, q}.
  - **MULT:** same, with the 64-bit result negated if `sign_a` ^ `sign_b`.
  - **DIVU:** `lo`=q, `hi`=R.
  - **DIV:** quotient negated if `sign_a` ^ `sign_b`; remainder negated if `sign_a` (remainder takes the dividend's sign).
  - **DIV 0x80000000 / 0xFFFFFFFF:** yields `lo`=0x80000000, `hi`=0 naturally; no special case.
  - **Divide by zero:** `hi`=`rs_val` as latched, `lo`=0xFFFFFFFF, `div_by_zero`=1.

- **ALU drive outside ITER:** `alu_opselect`=0000, `alu_x`=0, `alu_y`=0.

- **Holding:** `hi`/`lo` hold between operations; they are written only in FIXUP.

- **`start` while `busy`:** ignored; no queueing.

- **`start` coincident with `done`:** accepted, since the FSM is already in IDLE.

- **Reset mid-operation:** immediate return to IDLE, all outputs cleared, no `done` pulse.

## Timing
- Edge 0 samples `start`; `busy`=1 from edge 0.
- Normal ops:
  - ITER occupies edges 1..32.
  - FIXUP at edge 33 updates `hi`/`lo`.
  - `done`=1 for the cycle after edge 33, with `busy`=0 in that same cycle.
  - Latency is 33 cycles, start-sample to `done`.
- Divide by zero: FIXUP at edge 1, `done` after edge 1 (latency 1).
- `done` is always exactly one cycle and never asserts without a preceding accepted `start`.
- The ALU path is combinational within the ITER cycle; there is no ALU pipelining.

## Test plan
- MULTU 0xFFFFFFFF × 0xFFFFFFFF → `hi`=0xFFFFFFFE, `lo`=0x00000001; `done` exactly 33 cycles after the start edge; `busy` high throughout.
- MULT −3 × 5 → `hi`=0xFFFFFFFF, `lo`=0xFFFFFFF1. MULT 0x80000000 × 0x80000000 → `hi`=0x40000000, `lo`=0.
- DIV −7 / 2 → `lo`=0xFFFFFFFD, `hi`=0xFFFFFFFF. DIVU 100 / 7 → `lo`=14, `hi`=2. DIV 0x80000000 / 0xFFFFFFFF → `lo`=0x80000000, `hi`=0.
- DIVU 0x64 / 0 → `div_by_zero`=1, `hi`=0x64, `lo`=0xFFFFFFFF, `done` 1 cycle after start. The next accepted start clears the flag.
- `start` pulsed at iteration 5 with different operands → ignored; the first result is unchanged. `start` held during the `done` cycle → a second operation begins and its `done` follows 33 cycles later.
- `rst_n` low during iteration 10 → `busy`/`hi`/`lo`/`done` = 0 immediately, no `done` after release, FSM in IDLE. A new MULTU 6 × 7 → `lo`=42.
